// File: rtl/alu_result_fifo.sv
// alu_result_fifo: result buffer between the ALU controller and its consumer.
// Each result is stored with its opcode tag and presented show-ahead over ready/valid.
// The producer cannot be stalled, so a result that arrives while the buffer is full
// and no pop happens is dropped. The drop sets a sticky flag and bumps a saturating counter.
module alu_result_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  input  logic                       clr_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DATA_W + TAG_W;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_not_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [EW-1:0]     w_head;

  // Handshake decode: a pop frees a slot in the same cycle, so a push at full is still accepted
  always_comb begin
    w_not_empty = (r_count != '0);
    w_full      = (r_count == LP_DEPTH);
    w_pop       = w_not_empty && out_ready;
    w_push      = in_valid && (!w_full || w_pop);
    w_drop      = in_valid && !w_push;
    w_head      = r_mem[r_rd_ptr];
  end

  // Storage write; the array carries no reset because unread slots are never observed
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {in_data, in_tag};
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Sticky overflow flag and saturating drop counter; a same-cycle clear beats a drop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Output drive: head is read combinationally from storage and forced to zero when
  // empty, so the reset value is met without clearing the storage array
  always_comb begin
    out_valid = w_not_empty;
    full      = w_full;
    count     = r_count;
    overflow  = r_overflow;
    drop_cnt  = r_drop_cnt;
    out_data  = '0;
    out_tag   = '0;
    if (w_not_empty) begin
      out_data = w_head[EW-1:TAG_W];
      out_tag  = w_head[TAG_W-1:0];
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard bench for alu_result_fifo.
// Accepted pushes are queued with {data, tag}. Each pop is compared against the
// front of the queue.
module tb_alu_result_fifo;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [CW-1:0]     count;
  logic              full;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              clr_ovf;

  int n_tests;
  int n_fail;

  logic [DATA_W+TAG_W-1:0] sb[$];

  alu_result_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t, input bit expect_accept);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    if (expect_accept) sb.push_back({d, t});
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_tests++;
      if (out_valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || drop_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got v=%0b c=%0d o=%0b d=%0d, want 0 0 0 0",
                 i, out_valid, count, overflow, drop_cnt);
      end
    end
    n_tests++;
    if (out_data !== '0 || out_tag !== '0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h tag=%0d full=%0b, want 0 0 0", out_data, out_tag, full);
    end
  endtask

  task automatic test_single();
    logic [DATA_W+TAG_W-1:0] exp;
    push(16'h00A5, 3'd2, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h00A5 || out_tag !== 3'd2 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_head: got v=%0b data=%h tag=%0d c=%0d, want 1 00a5 2 1",
               out_valid, out_data, out_tag, count);
    end
    // Head must hold while the consumer stalls
    cyc();
    cyc();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h00A5 || out_tag !== 3'd2) begin
      n_fail++;
      $display("FAIL single_stall: got v=%0b data=%h tag=%0d, want 1 00a5 2", out_valid, out_data, out_tag);
    end
    out_ready = 1'b1;
    exp = sb.pop_front();
    n_tests++;
    if ({out_data, out_tag} !== exp) begin
      n_fail++;
      $display("FAIL single_pop: got %h, want %h", {out_data, out_tag}, exp);
    end
    cyc();
    out_ready = 1'b0;
    n_tests++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty: got c=%0d v=%0b, want 0 0", count, out_valid);
    end
  endtask

  task automatic test_fill_wrap();
    logic [DATA_W+TAG_W-1:0] exp;
    for (int i = 0; i < 8; i++) push(DATA_W'(i + 1), TAG_W'(i), 1'b1);
    n_tests++;
    if (full !== 1'b1 || count !== CW'(8)) begin
      n_fail++;
      $display("FAIL fill_full: got full=%0b c=%0d, want 1 8", full, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_data, out_tag} !== exp) begin
        n_fail++;
        $display("FAIL fill_pop%0d: got v=%0b %h, want 1 %h", i, out_valid, {out_data, out_tag}, exp);
      end
      cyc();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(DATA_W'(9 + i), TAG_W'(5 + i), 1'b1);
    n_tests++;
    if (count !== CW'(3)) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d, want 3", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_data, out_tag} !== exp) begin
        n_fail++;
        $display("FAIL wrap_pop%0d: got v=%0b %h, want 1 %h", i, out_valid, {out_data, out_tag}, exp);
      end
      cyc();
    end
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL wrap_empty: got v=%0b c=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W+TAG_W-1:0] exp;
    for (int i = 0; i < 8; i++) push(DATA_W'(i + 1), TAG_W'(7 - i), 1'b1);
    push(16'h1111, 3'd1, 1'b0);
    push(16'h2222, 3'd2, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || drop_cnt !== DROP_W'(2) || count !== CW'(8)) begin
      n_fail++;
      $display("FAIL ovf_flag: got o=%0b d=%0d c=%0d, want 1 2 8", overflow, drop_cnt, count);
    end
    // Clear in the same cycle as another drop: clear wins
    clr_ovf = 1'b1;
    push(16'h4444, 3'd4, 1'b0);
    clr_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b0 || drop_cnt !== '0 || count !== CW'(8)) begin
      n_fail++;
      $display("FAIL ovf_clr_wins: got o=%0b d=%0d c=%0d, want 0 0 8", overflow, drop_cnt, count);
    end
    // Saturation of the drop counter
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    in_tag   = 3'd3;
    for (int i = 0; i < 300; i++) cyc();
    in_valid = 1'b0;
    n_tests++;
    if (drop_cnt !== '1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_saturate: got d=%0d o=%0b, want 255 1", drop_cnt, overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_data, out_tag} !== exp) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: got v=%0b %h, want 1 %h", i, out_valid, {out_data, out_tag}, exp);
      end
      cyc();
    end
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: got v=%0b, want 0", out_valid);
    end
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b0 || drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL ovf_clear: got o=%0b d=%0d, want 0 0", overflow, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W+TAG_W-1:0] exp;
    for (int i = 0; i < 8; i++) push(DATA_W'(16'h0100 + i), TAG_W'(i), 1'b1);
    out_ready = 1'b1;
    exp = sb.pop_front();
    n_tests++;
    if ({out_data, out_tag} !== exp) begin
      n_fail++;
      $display("FAIL fpp_head: got %h, want %h", {out_data, out_tag}, exp);
    end
    push(16'h3333, 3'd6, 1'b1);
    out_ready = 1'b0;
    n_tests++;
    if (count !== CW'(8) || drop_cnt !== '0 || overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL fpp_count: got c=%0d d=%0d o=%0b f=%0b, want 8 0 0 1", count, drop_cnt, overflow, full);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_data, out_tag} !== exp) begin
        n_fail++;
        $display("FAIL fpp_pop%0d: got v=%0b %h, want 1 %h", i, out_valid, {out_data, out_tag}, exp);
      end
      cyc();
    end
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL fpp_empty: got v=%0b c=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W+TAG_W-1:0] exp;
    for (int i = 0; i < 5; i++) push(DATA_W'(16'h0200 + i), TAG_W'(i), 1'b1);
    n_tests++;
    if (count !== CW'(5)) begin
      n_fail++;
      $display("FAIL rstmid_pre: got c=%0d, want 5", count);
    end
    rst = 1'b1;
    push(16'h5555, 3'd5, 1'b0);
    rst = 1'b0;
    sb.delete();
    n_tests++;
    if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_state: got c=%0d v=%0b o=%0b data=%h, want 0 0 0 0",
               count, out_valid, overflow, out_data);
    end
    cyc();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nostore: got v=%0b, want 0", out_valid);
    end
    push(16'h6666, 3'd1, 1'b1);
    out_ready = 1'b1;
    exp = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || {out_data, out_tag} !== exp || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL rstmid_after: got v=%0b %h c=%0d, want 1 %h 1", out_valid, {out_data, out_tag}, count, exp);
    end
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    #2;
    test_reset();
    test_single();
    test_fill_wrap();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Buffers results produced by the ALU controller (alucon) and sits directly downstream of it.
- Captures each output word on its valid pulse, with an opcode tag for scoreboard correlation.
- Presents buffered entries to the consumer over a ready/valid handshake.
- alucon has no backpressure, so overflow is detected, counted and flagged rather than stalled.

Parameters:
- DATA_W, 16, width of the ALU result word (matches alucon out_put).
- TAG_W, 3, width of the opcode tag stored with each result (matches alucon fn).
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- DROP_W, 8, width of the saturating dropped-result counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  result strobe, driven from alucon valid.
- in_data  in  DATA_W  result word, driven from alucon out_put.
- in_tag  in  TAG_W  opcode tag, driven from the fn issued with the operation.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  DATA_W  head entry data.
- out_tag  out  TAG_W  head entry tag.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: set when a result is dropped.
- drop_cnt  out  DROP_W  number of dropped results, saturating.
- clr_ovf  in  1  clears overflow and drop_cnt.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, count=0, full=0, overflow=0, drop_cnt=0, out_data=0, out_tag=0. Read and write pointers=0.
- Reset mid-operation: all buffered entries are discarded. in_valid in the reset cycle is ignored.
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap DEPTH-1 -> 0. Occupancy is held in a separate counter.
- Push: occurs on a cycle where in_valid=1 and either count<DEPTH or a pop occurs in the same cycle. The entry is written {in_data,in_tag} at wr_ptr, and wr_ptr increments.
- Pop: occurs on a cycle where out_valid=1 and out_ready=1. rd_ptr increments.
- Show-ahead read: out_data/out_tag always reflect the entry at rd_ptr. They are registered, or driven combinationally from storage. When out_valid=0 their values are don't-care, apart from the reset value.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle with that data; there is no same-cycle bypass.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop.
- out_valid = (count != 0). full = (count == DEPTH).
- Full FIFO with in_valid=1 and a pop in the same cycle: the push is accepted, count stays DEPTH, and nothing is dropped.
- Full FIFO with in_valid=1 and no pop: the result is dropped.
  - overflow is set to 1 on the next edge.
  - drop_cnt increments, saturating at 2^DROP_W-1.
  - Storage and pointers are unchanged.
- clr_ovf=1: overflow=0 and drop_cnt=0 on the next edge. If a drop occurs in the same cycle, clear wins and the drop is not counted.
- Consumer protocol: out_ready is permitted while out_valid=0 and has no effect.
- Output stability: out_data and out_tag must stay stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO order. The tag stays paired with its data.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, then in_valid=0 for 10 cycles -> out_valid=0, count=0, overflow=0, drop_cnt=0 throughout.
- Single result: in_valid=1, in_data=16'h00A5, in_tag=3'd2 for one cycle, out_ready=0.
  - Next cycle: out_valid=1, out_data=16'h00A5, out_tag=2, count=1.
  - Then out_ready=1 for one cycle -> count=0, out_valid=0.
- Fill and wrap: push 8 results 0x0001..0x0008 with tags 0..7, out_ready=0 -> full=1, count=8.
  - Pop all 8 -> data returned in order 0x0001..0x0008, tags intact.
  - Push 3 more (0x0009..0x000B) and pop -> correct order across pointer wrap.
- Overflow: fill to 8, then push 0x1111 and 0x2222 with out_ready=0.
  - overflow=1, drop_cnt=2, count=8.
  - Popping yields 0x0001..0x0008 only.
  - clr_ovf=1 for one cycle -> overflow=0, drop_cnt=0.
- Full with simultaneous push+pop: at full, in_valid=1 with data 0x3333 and out_ready=1 in the same cycle.
  - count stays 8, drop_cnt=0.
  - 0x3333 emerges as the 8th subsequent pop.
- Reset mid-operation: with count=5, assert rst for 1 cycle while in_valid=1 -> count=0, out_valid=0, overflow=0 next cycle. The input present during reset is not stored.
